// File: rtl/vec_sweep_pkg.sv
// Shared definitions for the vector sweep generator: mode encodings, FSM states, parameter limits.
// Optional build macro used by vec_sweep_gen: VEC_SWEEP_GRAY_ORDER_EN (Gray-code vector ordering).
package vec_sweep_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  localparam int N_MIN    = 1;
  localparam int N_MAX    = 16;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/vec_sweep_ref.sv
// Combinational reference model: reduces the stimulus vector with the latched mode function.
module vec_sweep_ref
  import vec_sweep_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] vec_i,
  input  logic [1:0]   mode_i,
  output logic         expected_o
);

  always_comb begin
    expected_o = 1'b0;
    case (mode_i)
      MODE_OR:  expected_o = |vec_i;
      MODE_AND: expected_o = &vec_i;
      MODE_XOR: expected_o = ^vec_i;
      MODE_NOR: expected_o = ~|vec_i;
      default:  expected_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_sweep_gen.sv
// Exhaustive stimulus sweep over all 2^N vectors, each held HOLD cycles, counting DUT mismatches.
// Build macro VEC_SWEEP_GRAY_ORDER_EN selects Gray-code ordering instead of a binary count.
module vec_sweep_gen
  import vec_sweep_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dut_in,
  output logic [N-1:0] vec_out,
  output logic         expected,
  output logic [N:0]   mismatch_cnt,
  output logic         busy,
  output logic         done,
  output logic         pass
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]  IDX_LAST  = {N{1'b1}};

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      mode_q, mode_d;
  logic [N:0]      cnt_q, cnt_d;
  logic [N-1:0]    vec_q, vec_d;

  function automatic logic [N-1:0] order_f(input logic [N-1:0] i);
`ifdef VEC_SWEEP_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  vec_sweep_ref #(.N(N)) u_ref (
    .vec_i      (vec_q),
    .mode_i     (mode_q),
    .expected_o (expected)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          hold_d  = '0;
          cnt_d   = '0;
          mode_d  = mode;
          vec_d   = order_f('0);
        end
      end
      ST_RUN: begin
        // Only the final hold cycle of each vector is scored; earlier cycles let the DUT settle.
        if (hold_q == HOLD_LAST) begin
          if (dut_in != expected) cnt_d = cnt_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            vec_d   = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            hold_d = '0;
            vec_d  = order_f(idx_q + 1'b1);
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      mode_q  <= MODE_OR;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  assign vec_out      = vec_q;
  assign mismatch_cnt = cnt_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign pass         = done && (cnt_q == '0);

endmodule

// File: tb/tb_vec_sweep_gen.sv
// Randomized self-checking bench for vec_sweep_gen (N=4/HOLD=2 and N=3/HOLD=1 instances).
module tb_vec_sweep_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_r, sel, dut_in;
  logic [1:0] mode;

  wire start4 = start_r & ~sel;
  wire start3 = start_r & sel;

  logic [3:0] vec4;  logic exp4, busy4, done4, pass4;  logic [4:0] cnt4;
  logic [2:0] vec3;  logic exp3, busy3, done3, pass3;  logic [3:0] cnt3;

  vec_sweep_gen #(.N(4), .HOLD(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .dut_in(dut_in),
    .vec_out(vec4), .expected(exp4), .mismatch_cnt(cnt4),
    .busy(busy4), .done(done4), .pass(pass4)
  );

  vec_sweep_gen #(.N(3), .HOLD(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode), .dut_in(dut_in),
    .vec_out(vec3), .expected(exp3), .mismatch_cnt(cnt3),
    .busy(busy3), .done(done3), .pass(pass3)
  );

  wire [3:0] o_vec  = sel ? {1'b0, vec3} : vec4;
  wire [4:0] o_cnt  = sel ? {1'b0, cnt3} : cnt4;
  wire       o_exp  = sel ? exp3  : exp4;
  wire       o_busy = sel ? busy3 : busy4;
  wire       o_done = sel ? done3 : done4;
  wire       o_pass = sel ? pass3 : pass4;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ord(input int i);
`ifdef VEC_SWEEP_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // Reference reduction from the mode table, using plain arithmetic on the vector value.
  function automatic int ref_fn(input int m, input int v, input int n);
    int ones;
    ones = $countones(v);
    case (m)
      0:       return (v != 0) ? 1 : 0;
      1:       return (v == (1 << n) - 1) ? 1 : 0;
      2:       return ones % 2;
      default: return (v == 0) ? 1 : 0;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_vec"},  o_vec,  0);
    check_eq({tag, "_cnt"},  o_cnt,  0);
    check_eq({tag, "_pass"}, o_pass, 0);
  endtask

  // pol: 0 correct response, 1 tied high, 2 tied low, 3 random.
  task automatic run_sweep(input int s, input int m, input int pol,
                           input int glitch_at, input int rst_at);
    int n, hold, total, cnt, v, e;
    n     = s ? 3 : 4;
    hold  = s ? 1 : 2;
    total = hold << n;
    cnt   = 0;
    @(negedge clk);
    sel     = s[0];
    mode    = m[1:0];
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    mode    = 2'($urandom_range(0, 3));
    for (int k = 0; k < total; k++) begin
      v = ord(k / hold);
      e = ref_fn(m, v, n);
      check_eq("run_vec",  o_vec,  v);
      check_eq("run_exp",  o_exp,  e);
      check_eq("run_busy", o_busy, 1);
      check_eq("run_done", o_done, 0);
      check_eq("run_cnt",  o_cnt,  cnt);
      case (pol)
        0:       dut_in = (e != 0);
        1:       dut_in = 1'b1;
        2:       dut_in = 1'b0;
        default: dut_in = 1'($urandom_range(0, 1));
      endcase
      if ((k % hold == hold - 1) && (int'(dut_in) != e)) cnt++;
      start_r = (k == glitch_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        check_eq("rst_exp", o_exp, 0);
        start_r = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_idle("rst_noresume");
        end
        $display("sweep n=%0d hold=%0d mode=%0d reset at cycle %0d", n, hold, m, k);
        return;
      end
      @(negedge clk);
    end
    start_r = 1'b0;
    check_eq("end_busy", o_busy, 0);
    check_eq("end_done", o_done, 1);
    check_eq("end_vec",  o_vec,  0);
    check_eq("end_cnt",  o_cnt,  cnt);
    check_eq("end_pass", o_pass, (cnt == 0) ? 1 : 0);
    check_eq("end_exp",  o_exp,  ref_fn(m, 0, n));
    @(negedge clk);
    check_eq("hold_done", o_done, 1);
    check_eq("hold_cnt",  o_cnt,  cnt);
    $display("sweep n=%0d hold=%0d mode=%0d pol=%0d mismatches=%0d", n, hold, m, pol, cnt);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_r = 1'b0;
    sel     = 1'b0;
    mode    = 2'b00;
    dut_in  = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    run_sweep(0, 0, 0, -1, -1);   // OR, correct response: pass
    run_sweep(0, 0, 1, -1, -1);   // OR, tied high: one mismatch at 0000
    run_sweep(1, 1, 2, -1, -1);   // AND, tied low: one mismatch at 111
    run_sweep(1, 2, 2, -1, -1);   // XOR, tied low: four mismatches
    run_sweep(0, 3, 3, 5, -1);    // start during RUN ignored
    run_sweep(0, 3, 0, 31, -1);   // start on final compare ignored
    run_sweep(0, 3, 3, -1, 10);   // reset mid-sweep
    for (int i = 0; i < 8; i++)
      run_sweep(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
